// File: rtl/pipe_ctrl_unit.sv
// ID-stage control decode, ID/EX control register and load-use hazard stall FSM.
// Branch flushes and load-use stalls are resolved here by inserting bubbles into ID/EX.
module pipe_ctrl_unit #(
    parameter int OPCODE_W   = 7,
    parameter int REG_W      = 5,
    parameter int ALUOP_W    = 2,
    parameter int LOAD_STALL = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                id_valid_i,
    input  logic [OPCODE_W-1:0] id_op_i,
    input  logic [REG_W-1:0]    id_rs1_i,
    input  logic [REG_W-1:0]    id_rs2_i,
    input  logic [REG_W-1:0]    id_rd_i,
    input  logic                flush_i,
    output logic                stall_o,
    output logic                illegal_o,
    output logic                ex_valid_o,
    output logic                ex_regwrite_o,
    output logic                ex_memtoreg_o,
    output logic                ex_memread_o,
    output logic                ex_memwrite_o,
    output logic [ALUOP_W-1:0]  ex_aluop_o,
    output logic                ex_alusrc_o,
    output logic                ex_branch_o,
    output logic [REG_W-1:0]    ex_rd_o
);

    localparam logic [OPCODE_W-1:0] OP_R      = OPCODE_W'(7'b0110011);
    localparam logic [OPCODE_W-1:0] OP_I      = OPCODE_W'(7'b0010011);
    localparam logic [OPCODE_W-1:0] OP_LOAD   = OPCODE_W'(7'b0000011);
    localparam logic [OPCODE_W-1:0] OP_STORE  = OPCODE_W'(7'b0100011);
    localparam logic [OPCODE_W-1:0] OP_BRANCH = OPCODE_W'(7'b1100011);

    typedef enum logic {RUN, STALL} state_t;

    state_t              state_reg, state_next;
    logic [3:0]          cnt_reg, cnt_next;

    logic                dec_known, dec_rs2_used;
    logic                dec_regwrite, dec_memtoreg, dec_memread, dec_memwrite;
    logic [ALUOP_W-1:0]  dec_aluop;
    logic                dec_alusrc, dec_branch;
    logic                hazard;
    logic                bubble;
    logic                capture;

    always_comb begin
        dec_known    = 1'b0;
        dec_rs2_used = 1'b0;
        dec_regwrite = 1'b0;
        dec_memtoreg = 1'b0;
        dec_memread  = 1'b0;
        dec_memwrite = 1'b0;
        dec_aluop    = '0;
        dec_alusrc   = 1'b0;
        dec_branch   = 1'b0;
        case (id_op_i)
            OP_R: begin
                dec_known    = 1'b1;
                dec_rs2_used = 1'b1;
                dec_regwrite = 1'b1;
                dec_aluop    = ALUOP_W'(2'b01);
            end
            OP_I: begin
                dec_known    = 1'b1;
                dec_regwrite = 1'b1;
                dec_alusrc   = 1'b1;
            end
            OP_LOAD: begin
                dec_known    = 1'b1;
                dec_regwrite = 1'b1;
                dec_memtoreg = 1'b1;
                dec_memread  = 1'b1;
                dec_alusrc   = 1'b1;
            end
            OP_STORE: begin
                dec_known    = 1'b1;
                dec_rs2_used = 1'b1;
                dec_memwrite = 1'b1;
                dec_aluop    = ALUOP_W'(2'b01);
                dec_alusrc   = 1'b1;
            end
            OP_BRANCH: begin
                dec_known    = 1'b1;
                dec_rs2_used = 1'b1;
                dec_aluop    = ALUOP_W'(2'b11);
                dec_branch   = 1'b1;
            end
            default: ;
        endcase
    end

    assign illegal_o = id_valid_i & ~dec_known;

    // Unknown opcodes read no sources, so they can never be the consumer of a hazard.
    assign hazard = id_valid_i & ex_valid_o & ex_memread_o & (ex_rd_o != '0) & dec_known &
                    ((id_rs1_i == ex_rd_o) | (dec_rs2_used & (id_rs2_i == ex_rd_o)));

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        stall_o    = 1'b0;
        bubble     = 1'b0;
        if (flush_i) begin
            state_next = RUN;
            cnt_next   = 4'd0;
            bubble     = 1'b1;
        end else begin
            case (state_reg)
                RUN: begin
                    if (hazard) begin
                        stall_o = 1'b1;
                        bubble  = 1'b1;
                        if (LOAD_STALL > 1) begin
                            state_next = STALL;
                            cnt_next   = 4'(LOAD_STALL - 1);
                        end
                    end
                end
                STALL: begin
                    stall_o  = 1'b1;
                    bubble   = 1'b1;
                    cnt_next = cnt_reg - 4'd1;
                    if (cnt_reg == 4'd1) begin
                        state_next = RUN;
                    end
                end
                default: begin
                    state_next = RUN;
                    cnt_next   = 4'd0;
                end
            endcase
        end
    end

    assign capture = id_valid_i & ~bubble;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= RUN;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Anything not captured (stall, flush, empty ID slot) loads an all-zero bubble.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_valid_o    <= 1'b0;
            ex_regwrite_o <= 1'b0;
            ex_memtoreg_o <= 1'b0;
            ex_memread_o  <= 1'b0;
            ex_memwrite_o <= 1'b0;
            ex_aluop_o    <= '0;
            ex_alusrc_o   <= 1'b0;
            ex_branch_o   <= 1'b0;
            ex_rd_o       <= '0;
        end else if (capture) begin
            ex_valid_o    <= 1'b1;
            ex_regwrite_o <= dec_regwrite;
            ex_memtoreg_o <= dec_memtoreg;
            ex_memread_o  <= dec_memread;
            ex_memwrite_o <= dec_memwrite;
            ex_aluop_o    <= dec_aluop;
            ex_alusrc_o   <= dec_alusrc;
            ex_branch_o   <= dec_branch;
            ex_rd_o       <= id_rd_i;
        end else begin
            ex_valid_o    <= 1'b0;
            ex_regwrite_o <= 1'b0;
            ex_memtoreg_o <= 1'b0;
            ex_memread_o  <= 1'b0;
            ex_memwrite_o <= 1'b0;
            ex_aluop_o    <= '0;
            ex_alusrc_o   <= 1'b0;
            ex_branch_o   <= 1'b0;
            ex_rd_o       <= '0;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Scoreboard bench for pipe_ctrl_unit: instance 0 uses a 1-cycle load stall, instance 1 a 3-cycle one.
module tb_pipe_ctrl_unit;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       memtoreg;
        logic       memread;
        logic       memwrite;
        logic [1:0] aluop;
        logic       alusrc;
        logic       branch;
        logic [4:0] rd;
    } ex_t;

    logic clk;
    logic rst_n;
    logic mon_en;

    logic       id_valid [2];
    logic [6:0] id_op    [2];
    logic [4:0] id_rs1   [2];
    logic [4:0] id_rs2   [2];
    logic [4:0] id_rd    [2];
    logic       flush    [2];
    logic       stall    [2];
    logic       illegal  [2];
    logic       ex_valid [2];
    logic       ex_regwrite [2];
    logic       ex_memtoreg [2];
    logic       ex_memread  [2];
    logic       ex_memwrite [2];
    logic [1:0] ex_aluop    [2];
    logic       ex_alusrc   [2];
    logic       ex_branch   [2];
    logic [4:0] ex_rd       [2];

    logic [1:0] qc [2][$];
    ex_t        qe [2][$];

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ex_t act_ex(input int d);
        return {ex_valid[d], ex_regwrite[d], ex_memtoreg[d], ex_memread[d], ex_memwrite[d],
                ex_aluop[d], ex_alusrc[d], ex_branch[d], ex_rd[d]};
    endfunction

    // Hand-written decode table for a captured, non-bubble instruction.
    function automatic ex_t exp_ex(input logic [6:0] op, input logic [4:0] rd);
        ex_t e;
        e = '0;
        e.valid = 1'b1;
        e.rd    = rd;
        case (op)
            OP_R:  begin e.regwrite = 1'b1; e.aluop = 2'b01; end
            OP_I:  begin e.regwrite = 1'b1; e.alusrc = 1'b1; end
            OP_LD: begin e.regwrite = 1'b1; e.memtoreg = 1'b1; e.memread = 1'b1; e.alusrc = 1'b1; end
            OP_ST: begin e.memwrite = 1'b1; e.aluop = 2'b01; e.alusrc = 1'b1; end
            OP_BR: begin e.aluop = 2'b11; e.branch = 1'b1; end
            default: ;
        endcase
        return e;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            pipe_ctrl_unit #(
                .OPCODE_W  (7),
                .REG_W     (5),
                .ALUOP_W   (2),
                .LOAD_STALL((gi == 0) ? 1 : 3)
            ) u_dut (
                .clk_i        (clk),
                .rst_i        (rst_n),
                .id_valid_i   (id_valid[gi]),
                .id_op_i      (id_op[gi]),
                .id_rs1_i     (id_rs1[gi]),
                .id_rs2_i     (id_rs2[gi]),
                .id_rd_i      (id_rd[gi]),
                .flush_i      (flush[gi]),
                .stall_o      (stall[gi]),
                .illegal_o    (illegal[gi]),
                .ex_valid_o   (ex_valid[gi]),
                .ex_regwrite_o(ex_regwrite[gi]),
                .ex_memtoreg_o(ex_memtoreg[gi]),
                .ex_memread_o (ex_memread[gi]),
                .ex_memwrite_o(ex_memwrite[gi]),
                .ex_aluop_o   (ex_aluop[gi]),
                .ex_alusrc_o  (ex_alusrc[gi]),
                .ex_branch_o  (ex_branch[gi]),
                .ex_rd_o      (ex_rd[gi])
            );

            // Mid-cycle monitor: current stall/illegal and the bundle captured at the last edge.
            always @(negedge clk) begin
                logic [1:0] c;
                ex_t        e;
                if (mon_en && qc[gi].size() > 0) begin
                    c = qc[gi].pop_front();
                    n_checks++;
                    if ({stall[gi], illegal[gi]} !== c) begin
                        n_fail++;
                        $display("FAIL dut%0d stall/illegal: got %b expected %b", gi,
                                 {stall[gi], illegal[gi]}, c);
                    end else
                        $display("dut%0d stall/illegal ok %b", gi, c);
                end
                if (mon_en && qe[gi].size() > 0) begin
                    e = qe[gi].pop_front();
                    n_checks++;
                    if (act_ex(gi) !== e) begin
                        n_fail++;
                        $display("FAIL dut%0d ex bundle: got %h expected %h", gi, act_ex(gi), e);
                    end else
                        $display("dut%0d ex bundle ok %h", gi, e);
                end
            end
        end
    endgenerate

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end else
            $display("%s ok %h", name, got);
    endtask

    // Called just after a rising edge; applies one cycle of ID inputs and queues expectations.
    task automatic step(input int d, input logic v, input logic [6:0] op, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] rd, input logic fl,
                        input logic exp_stall, input logic exp_ill);
        ex_t e;
        id_valid[d] = v;
        id_op[d]    = op;
        id_rs1[d]   = r1;
        id_rs2[d]   = r2;
        id_rd[d]    = rd;
        flush[d]    = fl;
        qc[d].push_back({exp_stall, exp_ill});
        if (!v || fl || exp_stall) e = '0;
        else e = exp_ex(op, rd);
        @(posedge clk);
        qe[d].push_back(e);
        #1;
    endtask

    task automatic idle(input int d);
        step(d, 1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n  = 1'b0;
        mon_en = 1'b1;
        for (int d = 0; d < 2; d++) begin
            id_valid[d] = 1'b0; id_op[d] = '0; id_rs1[d] = '0;
            id_rs2[d] = '0; id_rd[d] = '0; flush[d] = 1'b0;
        end
        #12;
        chk("reset ex dut0", 32'(act_ex(0)), 32'd0);
        chk("reset ex dut1", 32'(act_ex(1)), 32'd0);
        chk("reset stall dut1", 32'(stall[1]), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // LOAD_STALL=1: R capture, load-use with one bubble, illegal opcode handling
        step(0, 1, OP_R,   5'd1, 5'd2, 5'd3, 0, 0, 0);
        step(0, 1, OP_LD,  5'd1, 5'd0, 5'd5, 0, 0, 0);
        step(0, 1, OP_R,   5'd5, 5'd6, 5'd7, 0, 1, 0);
        step(0, 1, OP_R,   5'd5, 5'd6, 5'd7, 0, 0, 0);
        step(0, 1, OP_BAD, 5'd0, 5'd0, 5'd0, 0, 0, 1);
        step(0, 0, OP_BAD, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        idle(0);

        // LOAD_STALL=3: three bubbles, then rd=0 and rs2-unused cases
        step(1, 1, OP_LD, 5'd0, 5'd0, 5'd5, 0, 0, 0);
        step(1, 1, OP_R,  5'd5, 5'd1, 5'd8, 0, 1, 0);
        step(1, 1, OP_R,  5'd5, 5'd1, 5'd8, 0, 1, 0);
        step(1, 1, OP_R,  5'd5, 5'd1, 5'd8, 0, 1, 0);
        step(1, 1, OP_R,  5'd5, 5'd1, 5'd8, 0, 0, 0);
        step(1, 1, OP_LD, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        step(1, 1, OP_R,  5'd0, 5'd0, 5'd4, 0, 0, 0);
        step(1, 1, OP_LD, 5'd1, 5'd0, 5'd5, 0, 0, 0);
        step(1, 1, OP_I,  5'd1, 5'd5, 5'd6, 0, 0, 0);
        // flush in the second stall cycle abandons the stall
        step(1, 1, OP_LD, 5'd1, 5'd0, 5'd5, 0, 0, 0);
        step(1, 1, OP_R,  5'd5, 5'd1, 5'd8, 0, 1, 0);
        step(1, 1, OP_R,  5'd5, 5'd1, 5'd8, 1, 0, 0);
        step(1, 1, OP_I,  5'd2, 5'd0, 5'd10, 0, 0, 0);
        step(1, 1, OP_ST, 5'd1, 5'd2, 5'd0, 0, 0, 0);
        idle(1);

        // asynchronous reset in the middle of a stall
        step(1, 1, OP_LD, 5'd0, 5'd0, 5'd5, 0, 0, 0);
        id_valid[0] = 1'b1; id_op[0] = OP_R; id_rs1[0] = 5'd1; id_rs2[0] = 5'd2; id_rd[0] = 5'd3;
        step(1, 1, OP_R,  5'd5, 5'd1, 5'd8, 0, 1, 0);
        @(negedge clk); #1;
        chk("mid-stall stall dut1", 32'(stall[1]), 32'd1);
        chk("pre-reset ex dut0", 32'(act_ex(0)), 32'(exp_ex(OP_R, 5'd3)));
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("async reset stall dut1", 32'(stall[1]), 32'd0);
        chk("async reset ex dut1", 32'(act_ex(1)), 32'd0);
        chk("async reset ex dut0", 32'(act_ex(0)), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        id_valid[0] = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;
        step(1, 1, OP_BR, 5'd5, 5'd8, 5'd0, 0, 0, 0);
        idle(1);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard drained", 32'(qc[0].size() + qc[1].size() + qe[0].size() + qe[1].size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Next-generation control unit for the 5-stage RISC-V pipeline.
- Decodes the ID-stage opcode into the control bundle (RegWrite, MemtoReg, MemRead, MemWrite, ALUOp, ALUSrc, Branch).
- Owns the ID/EX control register and detects load-use hazards with a configurable stall length.
- Inserts bubbles and handles branch flushes, so the datapath needs no separate hazard unit for control.

Parameters:
- OPCODE_W, 7, opcode width.
- REG_W, 5, register-address width.
- ALUOP_W, 2, ALUOp width; encodings are zero-extended to this width.
- LOAD_STALL, 1, stall cycles per load-use hazard; legal range 1..15.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- id_valid_i  in  1  IF/ID holds a real instruction.
- id_op_i  in  OPCODE_W  ID-stage opcode.
- id_rs1_i  in  REG_W  ID-stage rs1.
- id_rs2_i  in  REG_W  ID-stage rs2.
- id_rd_i  in  REG_W  ID-stage rd.
- flush_i  in  1  branch taken; kill the ID instruction.
- stall_o  out  1  hold PC and IF/ID (combinational).
- illegal_o  out  1  ID opcode is valid but unknown (combinational).
- ex_valid_o  out  1  ID/EX holds a real instruction.
- ex_regwrite_o  out  1  registered control.
- ex_memtoreg_o  out  1  registered control.
- ex_memread_o  out  1  registered control.
- ex_memwrite_o  out  1  registered control.
- ex_aluop_o  out  ALUOP_W  registered control.
- ex_alusrc_o  out  1  registered control.
- ex_branch_o  out  1  registered control.
- ex_rd_o  out  REG_W  registered rd.

Behaviour:
- Decode, given as RegWrite, MemtoReg, MemRead, MemWrite, ALUOp, ALUSrc, Branch:
  - R (0110011): 1,0,0,0,01,0,0.
  - I (0010011): 1,0,0,0,00,1,0.
  - LOAD (0000011): 1,1,1,0,00,1,0.
  - STORE (0100011): 0,0,0,1,01,1,0.
  - BRANCH (1100011): 0,0,0,0,11,0,1.
  - Any other opcode: all zero, and illegal_o=id_valid_i.
  - Decode is fully combinational with defaults: no latches, every output is assigned on every path.
- Source use:
  - rs1 is used by all five classes.
  - rs2 is used by R, STORE and BRANCH only.
- Hazard condition: id_valid_i & ex_valid_o & ex_memread_o & ex_rd_o!=0 & (rs1 match | rs2-used & rs2 match).
- Bubble: ID/EX loads ex_valid=0 with all control bits 0 and ex_rd=0.
- FSM states RUN and STALL, with a 4-bit counter cnt.
  - RUN, hazard, no flush:
    - stall_o=1 and a bubble enters ID/EX.
    - If LOAD_STALL>1, go to STALL with cnt=LOAD_STALL-1; otherwise stay in RUN.
  - STALL:
    - stall_o=1, a bubble enters ID/EX, cnt decrements.
    - When cnt==1 at the edge, go to RUN.
    - Net effect: stall_o is high for exactly LOAD_STALL consecutive cycles starting at the detection cycle.
  - RUN, no hazard, no flush: ID/EX captures the decoded bundle, ex_valid=id_valid_i, ex_rd=id_rd_i.
  - id_valid_i=0: treated as a bubble source, no hazard, illegal_o=0.
- flush_i has priority over everything:
  - stall_o=0 and a bubble enters ID/EX.
  - FSM goes to RUN and cnt clears, abandoning any stall in progress.
- Reset:
  - rst_i=0, asynchronously: FSM=RUN, cnt=0, all ex_* outputs 0.
  - stall_o and illegal_o follow their inputs combinationally; stall_o=0 while in reset.
  - Reset mid-stall ends the stall immediately.
- Latency: decode to ex_* outputs is one cycle; there is no pass-through path from ID inputs to ex_*.

Test Plan:
- Reset then release; apply valid R-type (op 0110011, rd=3) -> next cycle ex_valid=1, ex_regwrite=1, ex_aluop=01, ex_alusrc=0, ex_rd=3, stall_o=0 throughout.
- LOAD rd=5 then ADD rs1=5 (LOAD_STALL=1) -> stall_o=1 for exactly 1 cycle; ex_valid=0 in the bubble cycle; ADD captured the following cycle.
- Same sequence with LOAD_STALL=3 -> stall_o high for 3 consecutive cycles, 3 bubbles, then ADD. Repeat with rd=0 -> no stall. Repeat with an I-type consumer whose rs2=5 -> no stall.
- flush_i asserted in the 2nd stall cycle of a LOAD_STALL=3 hazard -> stall_o=0 that cycle, bubble enters, FSM back in RUN, next instruction decodes normally.
- Opcode 1111111 with id_valid_i=1 -> illegal_o=1, next-cycle ex_* all 0 with ex_valid=1. Same opcode with id_valid_i=0 -> illegal_o=0.
- Assert rst_i=0 mid-stall, asynchronously between edges -> ex_* clear immediately and stall_o drops. After release the FSM is in RUN and a BRANCH decodes to ex_branch=1, ex_aluop=11.
